// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Digit-serial unsigned subtractor, diff = a - b - bin, with
//            valid/ready handshakes on both sides. Each RUN cycle handles
//            DIGIT bits, so a result takes WIDTH/DIGIT cycles.
// Options  : define SERIAL_SUBTRACTOR_OVF_EN to add the two's-complement
//            overflow output 'ovf'.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1   // WIDTH must be a multiple of DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned        C_STEPS = WIDTH / DIGIT;
  localparam int unsigned        C_CNT_W = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_a;          // minuend, shifted right each step
  logic [WIDTH-1:0]   r_b;          // subtrahend, shifted right each step
  logic [WIDTH-1:0]   r_acc;        // result bits collected from the top down
  logic               r_borrow;     // borrow carried between steps
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic [DIGIT-1:0]   w_digit;
  logic               w_borrow_next;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_accept;
  logic               w_last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
`endif

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  // State register: reset forces IDLE, which aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept in IDLE, count STEPS cycles in RUN, hold in DONE
  // until the consumer takes the result.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone; no accept during handoff.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // One DIGIT-wide ripple of full subtractors fed by the registered borrow.
  always_comb begin : p_sub
    logic br;
    br      = r_borrow;
    w_digit = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      w_digit[i] = r_a[i] ^ r_b[i] ^ br;
      br         = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & br);
    end
    w_borrow_next = br;
  end

  // New digits enter at the top so the first digit ends up at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_acc_full
      assign w_acc_next = w_digit;
    end else begin : g_acc_shift
      assign w_acc_next = {w_digit, r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Datapath: latch operands on accept, step in RUN, publish on the last step.
  // Results go to separate output registers so diff/bout only change once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_a_msb  <= a[WIDTH-1];
      r_b_msb  <= b[WIDTH-1];
`endif
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_acc    <= w_acc_next;
      r_borrow <= w_borrow_next;
      r_cnt    <= r_cnt + C_CNT_W'(1);
      if (w_last) begin
        r_diff <= w_acc_next;
        r_bout <= w_borrow_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_acc_next[WIDTH-1]);
`endif
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Scoreboard bench for serial_subtractor, DIGIT=1 and DIGIT=4
//            instances at WIDTH=8. Honours SERIAL_SUBTRACTOR_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    int         acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  logic       rst1, iv1, ir1, bin1, ov1, or1, bout1, ovf1;
  logic [7:0] a1, b1, diff1;
  logic       rst4, iv4, ir4, bin4, ov4, or4, bout4, ovf4;
  logic [7:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .bin(bin1), .out_valid(ov1), .out_ready(or1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .bin(bin4), .out_valid(ov4), .out_ready(or4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor for the DIGIT=1 instance: latency on rise, contents on handshake.
  logic pv1 = 1'b0;
  always @(negedge clk) begin
    #1;
    if (ov1 && !pv1) begin
      if (q1.size() == 0) fail("dut1 spurious out_valid");
      else check("dut1 latency", cyc - q1[0].acc, 8);
    end
    if (ov1 && or1) begin
      if (q1.size() == 0) fail("dut1 unexpected result");
      else begin
        e1 = q1.pop_front();
        check("dut1 diff", diff1, e1.d);
        check("dut1 bout", bout1, e1.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("dut1 ovf", ovf1, e1.ov);
`endif
      end
    end
    pv1 = ov1;
  end

  // Monitor for the DIGIT=4 instance.
  logic pv4 = 1'b0;
  always @(negedge clk) begin
    #1;
    if (ov4 && !pv4) begin
      if (q4.size() == 0) fail("dut4 spurious out_valid");
      else check("dut4 latency", cyc - q4[0].acc, 2);
    end
    if (ov4 && or4) begin
      if (q4.size() == 0) fail("dut4 unexpected result");
      else begin
        e4 = q4.pop_front();
        check("dut4 diff", diff4, e4.d);
        check("dut4 bout", bout4, e4.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("dut4 ovf", ovf4, e4.ov);
`endif
      end
    end
    pv4 = ov4;
  end

  // Offer one operand set; called and returning at a falling edge. Operands
  // are scrambled after acceptance to show the in-flight result is unaffected.
  task automatic send(input int which, input logic [7:0] a, input logic [7:0] b,
                      input logic bi, input logic [7:0] ed, input logic eb,
                      input logic eo, output int waited);
    exp_t e;
    int   n;
    n = 0;
    if (which == 1) begin iv1 = 1'b1; a1 = a; b1 = b; bin1 = bi; end
    else            begin iv4 = 1'b1; a4 = a; b4 = b; bin4 = bi; end
    while (((which == 1) ? ir1 : ir4) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (n >= 50) begin
      fail("send timeout waiting for in_ready");
    end else begin
      e.d = ed; e.bo = eb; e.ov = eo; e.acc = cyc + 1;
      if (which == 1) q1.push_back(e);
      else            q4.push_back(e);
    end
    @(negedge clk);
    if (which == 1) begin
      iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); bin1 = 1'($urandom);
    end else begin
      iv4 = 1'b0; a4 = 8'($urandom); b4 = 8'($urandom); bin4 = 1'($urandom);
    end
  endtask

  // DIGIT=1 vectors: a, b, bin, diff, bout, ovf (hand computed)
  logic [7:0] v_a  [7] = '{8'h00, 8'hA5, 8'h5A, 8'h80, 8'h05, 8'hFF, 8'h10};
  logic [7:0] v_b  [7] = '{8'h01, 8'h3C, 8'h5A, 8'h01, 8'h03, 8'hFF, 8'h20};
  logic       v_bi [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
  logic [7:0] v_d  [7] = '{8'hFF, 8'h69, 8'hFF, 8'h7F, 8'h02, 8'hFF, 8'hF0};
  logic       v_bo [7] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic       v_ov [7] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

  // DIGIT=4 bit-0 truth table, index = {a0, b0, bin}
  logic [7:0] t_d  [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'h00, 8'h00, 8'hFF};
  logic       t_bo [8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};

  initial begin
    int w;
    int n;
    logic [2:0] idx;
    rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0; or1 = 1'b1;
    rst4 = 1'b1; iv4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; or4 = 1'b1;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);

    check("reset dut1 in_ready", ir1, 1);
    check("reset dut1 out_valid", ov1, 0);
    check("reset dut1 diff", diff1, 8'h00);
    check("reset dut1 bout", bout1, 0);
    check("reset dut4 in_ready", ir4, 1);
    check("reset dut4 out_valid", ov4, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("reset dut1 ovf", ovf1, 0);
`endif

    for (int i = 0; i < 7; i++)
      send(1, v_a[i], v_b[i], v_bi[i], v_d[i], v_bo[i], v_ov[i], w);

    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      send(4, {7'd0, idx[2]}, {7'd0, idx[1]}, idx[0], t_d[i], t_bo[i], 1'b0, w);
    end

    // Back-pressure: result must hold and input pulses must be ignored.
    n = 0;
    while (!ir1 && n < 50) begin @(negedge clk); n++; end
    or1 = 1'b0;
    send(1, 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, w);
    n = 0;
    while (!ov1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail("dut1 out_valid timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", ov1, 1);
      check("bp diff", diff1, 8'h22);
      check("bp bout", bout1, 0);
      check("bp in_ready", ir1, 0);
      iv1 = ~iv1; a1 = 8'($urandom); b1 = 8'($urandom);
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    @(negedge clk);
    check("bp released out_valid", ov1, 0);

    // Reset in the middle of RUN discards the operation.
    send(1, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0, w);
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    q1.delete();
    @(negedge clk);
    rst1 = 1'b0;
    check("abort out_valid", ov1, 0);
    check("abort diff", diff1, 8'h00);
    check("abort bout", bout1, 0);
    check("abort in_ready", ir1, 1);
    send(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, w);
    check("accept right after reset", w, 0);

    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("drain timeout, results outstanding");
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
